spi_xip_apb: RTL and testbench

Execute-in-place bridge placed directly upstream of the APB SPI master. It accepts CPU APB transfers and forwards non-flash accesses to the SPI master's register file unchanged. Reads inside the flash window become a complete SPI master programming sequence: load the command and address, set the divider and slave select, start the transfer, poll for completion, then read the receive register. The CPU therefore sees flash as plain read-only memory.

---
 rtl/spi_xip_pkg.sv | 47 ++++
 rtl/spi_xip_apb_xfer.sv | 81 ++++++++
 rtl/spi_xip_apb.sv | 209 ++++++++++++++++++++
 tb/tb_spi_xip_apb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xip_pkg.sv
// -----------------------------------------------------------------------------
// spi_xip_pkg
// Shared constants for the SPI execute-in-place bridge: SPI master register
// offsets, the control word that launches a 64-bit flash read, the flash read
// opcode, the bridge state encoding and small helpers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package spi_xip_pkg;

  // SPI master register offsets, relative to spi_base.
  localparam logic [31:0] SPI_RX0  = 32'h0000_0000;
  localparam logic [31:0] SPI_TX1  = 32'h0000_0004;
  localparam logic [31:0] SPI_CTRL = 32'h0000_0010;
  localparam logic [31:0] SPI_DIV  = 32'h0000_0014;
  localparam logic [31:0] SPI_SS   = 32'h0000_0018;

  // ASS | TX_NEG | GO | CHAR_LEN=64 (encoded as 0x40).
  localparam logic [31:0] CTRL_XIP_START = 32'h0000_2540;
  localparam int          CTRL_GO_BIT    = 8;

  localparam logic [7:0]  FLASH_CMD_READ = 8'h03;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    BYPASS = 4'd1,
    TX1    = 4'd2,
    DIV    = 4'd3,
    SS     = 4'd4,
    CTRL   = 4'd5,
    POLL   = 4'd6,
    RX     = 4'd7,
    RESP   = 4'd8,
    ERR    = 4'd9
  } xip_state_e;

  // States that own an out-port transfer.
  function automatic logic is_step(input xip_state_e s);
    return (s == TX1) || (s == DIV) || (s == SS) ||
           (s == CTRL) || (s == POLL) || (s == RX);
  endfunction

  // Byte reversal: flash byte 0 (first on the wire, MSB of RX0) lands in [7:0].
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/spi_xip_apb_xfer.sv
// -----------------------------------------------------------------------------
// apb_master_xfer
// Runs one APB master transfer: a setup cycle (psel=1, penable=0) followed by
// access cycles until pready. A new start presented in the completing access
// cycle is accepted immediately, so chained transfers have no idle gap.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_i                    request a transfer (sampled when idle or on done)
//   addr_i, write_i, wdata_i   transfer attributes, latched on acceptance
//   done_o                     completing access cycle (combinational pulse)
//   rdata_o, err_o             read data / slave error, valid with done_o
//   psel_o .. pwdata_o         APB master request
//   pready_i, prdata_i, pslverr_i  APB master response
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module apb_master_xfer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic [31:0] paddr_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_e;

  phase_e      phase_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic        accept;

  assign done_o  = (phase_q == PH_ACCESS) && pready_i;
  assign err_o   = done_o && pslverr_i;
  assign rdata_o = prdata_i;
  assign accept  = start_i && ((phase_q == PH_IDLE) || done_o);

  assign psel_o    = (phase_q != PH_IDLE);
  assign penable_o = (phase_q == PH_ACCESS);
  assign paddr_o   = addr_q;
  assign pwrite_o  = write_q;
  assign pwdata_o  = wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= PH_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (phase_q)
        PH_IDLE:   if (start_i) phase_q <= PH_SETUP;
        PH_SETUP:  phase_q <= PH_ACCESS;
        PH_ACCESS: if (pready_i) phase_q <= start_i ? PH_SETUP : PH_IDLE;
        default:   phase_q <= PH_IDLE;
      endcase
      if (accept) begin
        addr_q  <= addr_i;
        write_q <= write_i;
        wdata_q <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/spi_xip_apb.sv
// -----------------------------------------------------------------------------
// spi_xip_apb
// Execute-in-place bridge in front of an APB SPI master. Accesses outside the
// flash window pass straight through to the SPI master. Reads inside the
// window are turned into the SPI programming sequence TX1, DIV, SS, CTRL,
// POLL (repeated while GO is set), RX, and the RX word is returned to the CPU.
// Writes into the window, or a slave error on any sequence step, return
// pslverr.
//
// Handshake: both APB ports follow APB semantics. A request is valid from the
// setup cycle (psel=1, penable=0); it completes on the access cycle
// (psel=1, penable=1) in which pready=1, and prdata/pslverr are only
// meaningful in that cycle. in_pready for XIP and error responses is a
// single-cycle pulse; the CPU holds psel/penable until it sees it.
//
// Configuration: define SPI_XIP_BSWAP_EN to byte-reverse the RX word.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   in_*                     APB slave port from the CPU
//   out_*                    APB master port to the SPI master
//   dbg_state                current bridge state
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_xip_apb
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] flash_addr_start = 32'h3000_0000,
  parameter logic [31:0] flash_addr_end   = 32'h3fff_ffff,
  parameter logic [31:0] spi_base         = 32'h1000_1000,
  parameter logic [31:0] spi_divider      = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  output xip_state_e  dbg_state
);

  xip_state_e  state_q, state_d;
  logic [21:0] word_q;     // flash word address captured at decode
  logic [31:0] data_q;     // RX word returned in RESP
  logic        kick_q;     // launches the first step one cycle after decode

  logic        decode, hit, bypass_req;
  logic        x_start, x_done, x_err, x_write;
  logic [31:0] x_addr, x_wdata, x_rdata;
  logic        x_psel, x_penable, x_pwrite;
  logic [31:0] x_paddr, x_pwdata;

  assign decode     = (state_q == IDLE) && in_psel && !in_penable;
  assign hit        = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
  // The setup cycle of a bypassed access is forwarded in the decode cycle
  // itself so pass-through costs no latency.
  assign bypass_req = (state_q == BYPASS) || (decode && !hit);
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (decode) state_d = !hit ? BYPASS : (in_pwrite ? ERR : TX1);
      BYPASS: if (out_pready) state_d = IDLE;
      TX1, DIV, SS, CTRL, POLL, RX: begin
        if (x_done) begin
          if (x_err) begin
            state_d = ERR;
          end else begin
            case (state_q)
              TX1:     state_d = DIV;
              DIV:     state_d = SS;
              SS:      state_d = CTRL;
              CTRL:    state_d = POLL;
              POLL:    state_d = x_rdata[CTRL_GO_BIT] ? POLL : RX;
              default: state_d = RESP;
            endcase
          end
        end
      end
      RESP, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Attributes of the step about to be launched. They are keyed on the next
  // state so the following step can be accepted in the completing cycle.
  always_comb begin
    x_addr  = spi_base;
    x_write = 1'b0;
    x_wdata = '0;
    case (state_d)
      TX1: begin
        x_addr  = spi_base + SPI_TX1;
        x_write = 1'b1;
        x_wdata = {FLASH_CMD_READ, word_q, 2'b00};
      end
      DIV: begin
        x_addr  = spi_base + SPI_DIV;
        x_write = 1'b1;
        x_wdata = spi_divider;
      end
      SS: begin
        x_addr  = spi_base + SPI_SS;
        x_write = 1'b1;
        x_wdata = 32'h0000_0001;
      end
      CTRL: begin
        x_addr  = spi_base + SPI_CTRL;
        x_write = 1'b1;
        x_wdata = CTRL_XIP_START;
      end
      POLL:    x_addr = spi_base + SPI_CTRL;
      RX:      x_addr = spi_base + SPI_RX0;
      default: ;
    endcase
  end

  assign x_start = kick_q || (x_done && !x_err && is_step(state_d));

  apb_master_xfer u_xfer (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .start_i   (x_start),
    .addr_i    (x_addr),
    .write_i   (x_write),
    .wdata_i   (x_wdata),
    .done_o    (x_done),
    .rdata_o   (x_rdata),
    .err_o     (x_err),
    .psel_o    (x_psel),
    .penable_o (x_penable),
    .paddr_o   (x_paddr),
    .pwrite_o  (x_pwrite),
    .pwdata_o  (x_pwdata),
    .pready_i  (out_pready),
    .prdata_i  (out_prdata),
    .pslverr_i (out_pslverr)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      word_q  <= '0;
      data_q  <= '0;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kick_q  <= (state_q == IDLE) && (state_d == TX1);
      if (decode && hit && !in_pwrite) word_q <= in_paddr[23:2];
      if ((state_q == RX) && x_done && !x_err) begin
`ifdef SPI_XIP_BSWAP_EN
        data_q <= bswap32(x_rdata);
`else
        data_q <= x_rdata;
`endif
      end
    end
  end

  always_comb begin
    if (bypass_req) begin
      out_paddr   = in_paddr;
      out_psel    = in_psel;
      out_penable = in_penable;
      out_pprot   = in_pprot;
      out_pwrite  = in_pwrite;
      out_pwdata  = in_pwdata;
      out_pstrb   = in_pstrb;
    end else begin
      out_paddr   = x_paddr;
      out_psel    = x_psel;
      out_penable = x_penable;
      out_pprot   = 3'b000;
      out_pwrite  = x_pwrite;
      out_pwdata  = x_pwdata;
      out_pstrb   = x_psel ? 4'hf : 4'h0;
    end
  end

  always_comb begin
    if (state_q == BYPASS) begin
      in_pready  = out_pready;
      in_prdata  = out_prdata;
      in_pslverr = out_pslverr;
    end else begin
      in_pready  = (state_q == RESP) || (state_q == ERR);
      in_prdata  = (state_q == RESP) ? data_q : '0;
      in_pslverr = (state_q == ERR);
    end
  end

endmodule

// File: tb/tb_spi_xip_apb.sv
// -----------------------------------------------------------------------------
// tb_spi_xip_apb
// Directed bench for spi_xip_apb with a small SPI-master register model on
// the out-port. Cycle numbers count the decode cycle as cycle 1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_xip_apb;
  import spi_xip_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] in_paddr, in_pwdata, in_prdata;
  logic        in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
  logic [2:0]  in_pprot, out_pprot;
  logic [3:0]  in_pstrb, out_pstrb;
  logic [31:0] out_paddr, out_pwdata, out_prdata;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  xip_state_e  dbg_state;

  always #5 clk = ~clk;

  spi_xip_apb dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_paddr    (in_paddr),
    .in_psel     (in_psel),
    .in_penable  (in_penable),
    .in_pprot    (in_pprot),
    .in_pwrite   (in_pwrite),
    .in_pwdata   (in_pwdata),
    .in_pstrb    (in_pstrb),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .in_pslverr  (in_pslverr),
    .out_paddr   (out_paddr),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pprot   (out_pprot),
    .out_pwrite  (out_pwrite),
    .out_pwdata  (out_pwdata),
    .out_pstrb   (out_pstrb),
    .out_pready  (out_pready),
    .out_prdata  (out_prdata),
    .out_pslverr (out_pslverr),
    .dbg_state   (dbg_state)
  );

  // ---------------- SPI master model ----------------
  int unsigned wait_cfg = 0;           // access wait states
  int unsigned wcnt     = 0;
  int          go_until = 0;           // GO reads as 1 while n_poll < go_until
  logic [31:0] rx_val   = 32'h0;
  logic [31:0] byp_val  = 32'h0;
  logic [31:0] err_addr = 32'h0;       // address that answers pslverr
  int          n_xfer = 0, n_wr = 0, n_poll = 0;
  logic [31:0] wa_log[64];
  logic [31:0] wd_log[64];

  assign out_pready  = out_psel && out_penable && (wcnt >= wait_cfg);
  assign out_pslverr = out_pready && (err_addr != 32'h0) && (out_paddr == err_addr);

  always_comb begin
    if (out_paddr == BASE + 32'h10)
      out_prdata = (n_poll < go_until) ? 32'h0000_2540 : 32'h0000_2440;
    else if (out_paddr == BASE)
      out_prdata = rx_val;
    else
      out_prdata = byp_val;
  end

  always @(posedge clk) begin
    if (out_psel && out_penable && !out_pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (out_psel && out_penable && out_pready) begin
      n_xfer <= n_xfer + 1;
      if (out_pwrite) begin
        wa_log[n_wr % 64] <= out_paddr;
        wd_log[n_wr % 64] <= out_pwdata;
        n_wr <= n_wr + 1;
      end else if (out_paddr == BASE + 32'h10) begin
        n_poll <= n_poll + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU transfer starting at posedge+2; returns at posedge+2 after it ends.
  task automatic cpu_xfer(input logic [31:0] addr, input logic wr,
                          output logic [31:0] rdata, output logic err, output int cyc,
                          output logic dec_psel, output logic [31:0] dec_paddr);
    in_paddr = addr; in_pwrite = wr; in_pwdata = 32'hdead_beef;
    in_pstrb = 4'hf; in_pprot = 3'b000; in_psel = 1'b1; in_penable = 1'b0;
    #1;
    dec_psel  = out_psel;
    dec_paddr = out_paddr;
    @(posedge clk); #2;
    in_penable = 1'b1;
    cyc = 2;
    #1;
    while (!in_pready && cyc < 300) begin
      @(posedge clk); #3;
      cyc++;
    end
    rdata = in_prdata;
    err   = in_pslverr;
    @(posedge clk); #2;
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  logic [31:0] rd, dpa, exp_rx;
  logic        er, dps;
  int          cyc, base_wr, base_poll, base_x;

  initial begin
`ifdef SPI_XIP_BSWAP_EN
    exp_rx = 32'h4433_2211;
`else
    exp_rx = 32'h1122_3344;
`endif
    resetn = 1'b0;
    in_paddr = '0; in_psel = 1'b0; in_penable = 1'b0; in_pprot = '0;
    in_pwrite = 1'b0; in_pwdata = '0; in_pstrb = '0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_in_resp", {in_pready, in_pslverr, 30'd0} | in_prdata, 32'h0);
    check("rst_out_ctl", {24'd0, out_psel, out_penable, out_pwrite, out_pprot, out_pstrb[1:0]} | {28'd0, out_pstrb}, 32'h0);
    check("rst_out_bus", out_paddr | out_pwdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #2;

    // Bypass read, two wait states.
    wait_cfg = 2; byp_val = 32'h1234_5678;
    cpu_xfer(32'h0F00_0010, 1'b0, rd, er, cyc, dps, dpa);
    check("byp_setup_psel", 32'(dps), 32'h1);
    check("byp_paddr", dpa, 32'h0F00_0010);
    check("byp_rdata", rd, 32'h1234_5678);
    check("byp_cycles", 32'(cyc), 32'd4);
    check("byp_err", 32'(er), 32'h0);
    wait_cfg = 0;

    // XIP read, single POLL, zero-wait slave.
    base_wr = n_wr; base_poll = n_poll;
    go_until = n_poll; rx_val = 32'h1122_3344;
    cpu_xfer(32'h3000_0104, 1'b0, rd, er, cyc, dps, dpa);
    check("xip_cycles", 32'(cyc), 32'd15);
    check("xip_rdata", rd, exp_rx);
    check("xip_err", 32'(er), 32'h0);
    check("xip_nwr", 32'(n_wr - base_wr), 32'd4);
    check("xip_npoll", 32'(n_poll - base_poll), 32'd1);
    exp_q.push_back(BASE + 32'h04); exp_q.push_back(32'h0300_0104);
    exp_q.push_back(BASE + 32'h14); exp_q.push_back(32'h0000_0001);
    exp_q.push_back(BASE + 32'h18); exp_q.push_back(32'h0000_0001);
    exp_q.push_back(BASE + 32'h10); exp_q.push_back(32'h0000_2540);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("xip_wr%0d_addr", i), wa_log[(base_wr + i) % 64], exp_q.pop_front());
      check($sformatf("xip_wr%0d_data", i), wd_log[(base_wr + i) % 64], exp_q.pop_front());
    end

    // XIP read, GO reads 1 three times.
    base_poll = n_poll;
    go_until = n_poll + 3; rx_val = 32'hA5C3_0F96;
    cpu_xfer(32'h3000_0104, 1'b0, rd, er, cyc, dps, dpa);
    check("poll4_cycles", 32'(cyc), 32'd21);
    check("poll4_npoll", 32'(n_poll - base_poll), 32'd4);
`ifdef SPI_XIP_BSWAP_EN
    check("poll4_rdata", rd, 32'h960F_C3A5);
`else
    check("poll4_rdata", rd, 32'hA5C3_0F96);
`endif

    // Write into the flash window.
    base_x = n_xfer;
    cpu_xfer(32'h3000_0000, 1'b1, rd, er, cyc, dps, dpa);
    check("fwr_setup_psel", 32'(dps), 32'h0);
    check("fwr_cycles", 32'(cyc), 32'd2);
    check("fwr_err", 32'(er), 32'h1);
    check("fwr_no_xfer", 32'(n_xfer - base_x), 32'd0);

    // Slave error on the SS write.
    base_wr = n_wr; base_x = n_xfer;
    go_until = n_poll; err_addr = BASE + 32'h18;
    cpu_xfer(32'h3000_0200, 1'b0, rd, er, cyc, dps, dpa);
    err_addr = 32'h0;
    check("sserr_err", 32'(er), 32'h1);
    check("sserr_cycles", 32'(cyc), 32'd9);
    check("sserr_nwr", 32'(n_wr - base_wr), 32'd3);
    check("sserr_nxfer", 32'(n_xfer - base_x), 32'd3);
    check("sserr_last_addr", wa_log[(base_wr + 2) % 64], BASE + 32'h18);

    // Reset asserted while polling.
    go_until = n_poll + 1000;
    in_paddr = 32'h3000_0300; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clk); #2;
    in_penable = 1'b1;
    for (int i = 0; i < 100 && dbg_state != POLL; i++) begin
      @(posedge clk); #2;
    end
    check("rst_mid_reached_poll", 32'(dbg_state), 32'(POLL));
    resetn = 1'b0;
    #1;
    check("rstp_in_resp", {in_pready, in_pslverr, 30'd0} | in_prdata, 32'h0);
    check("rstp_out_ctl", {25'd0, out_psel, out_penable, out_pwrite, out_pstrb}, 32'h0);
    check("rstp_out_pprot", 32'(out_pprot), 32'h0);
    check("rstp_out_bus", out_paddr | out_pwdata, 32'h0);
    check("rstp_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #2;
    in_psel = 1'b0; in_penable = 1'b0;
    go_until = n_poll;
    resetn = 1'b1;
    @(posedge clk); #2;
    rx_val = 32'h0BAD_F00D;
    cpu_xfer(32'h3FFF_FFFC, 1'b0, rd, er, cyc, dps, dpa);
    check("post_rst_cycles", 32'(cyc), 32'd15);
`ifdef SPI_XIP_BSWAP_EN
    check("post_rst_rdata", rd, 32'h0DF0_AD0B);
`else
    check("post_rst_rdata", rd, 32'h0BAD_F00D);
`endif
    check("post_rst_err", 32'(er), 32'h0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
